mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/cpu_pkg.sv | 13 +
 rtl/mem_wb_stage_if.sv | 40 ++++
 rtl/pipe_buf.sv | 31 +++
 rtl/mem_wb_stage.sv | 144 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: peripheral window base, timeout fill word
// and the MEM/WB peripheral-wait state encoding.
package cpu_pkg;

    localparam logic [31:0] PR_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] TMO_FILL    = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bundle: upstream entry, peripheral bridge return
// and the registered writeback outputs.
interface mem_wb_stage_if #(
    parameter int DW    = 32,
    parameter int NSIDE = 4
);
    logic                flush;
    logic                valid_in;
    logic                mem_rd_in;
    logic [DW-1:0]       pc_in;
    logic [DW-1:0]       instr_in;
    logic [DW-1:0]       aluout_in;
    logic [DW-1:0]       dmout_in;
    logic [NSIDE*DW-1:0] side_in;
    logic [DW-1:0]       pr_rd;
    logic                pr_rdy;
    logic                valid_out;
    logic [DW-1:0]       pc_out;
    logic [DW-1:0]       instr_out;
    logic [DW-1:0]       aluout_out;
    logic [DW-1:0]       rdata_out;
    logic [NSIDE*DW-1:0] side_out;
    logic                stall_out;
    logic                pr_err;

    modport master (
        output flush, valid_in, mem_rd_in, pc_in, instr_in,
        output aluout_in, dmout_in, side_in, pr_rd, pr_rdy,
        input  valid_out, pc_out, instr_out, aluout_out,
        input  rdata_out, side_out, stall_out, pr_err
    );

    modport slave (
        input  flush, valid_in, mem_rd_in, pc_in, instr_in,
        input  aluout_in, dmout_in, side_in, pr_rd, pr_rdy,
        output valid_out, pc_out, instr_out, aluout_out,
        output rdata_out, side_out, stall_out, pr_err
    );

endinterface

// File: rtl/pipe_buf.sv
// Width-generic pipeline register with synchronous clear
// (priority) and load enable.
module pipe_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register; loads from the peripheral window
// park the entry and stall upstream until bridge data or timeout.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int          DW      = 32,
    parameter int          NSIDE   = 4,
    parameter logic [31:0] PR_BASE = cpu_pkg::PR_BASE_DEF,
    parameter int          PR_TMO  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                valid_in,
    input  logic                mem_rd_in,
    input  logic [DW-1:0]       pc_in,
    input  logic [DW-1:0]       instr_in,
    input  logic [DW-1:0]       aluout_in,
    input  logic [DW-1:0]       dmout_in,
    input  logic [NSIDE*DW-1:0] side_in,
    input  logic [DW-1:0]       pr_rd,
    input  logic                pr_rdy,
    output logic                valid_out,
    output logic [DW-1:0]       pc_out,
    output logic [DW-1:0]       instr_out,
    output logic [DW-1:0]       aluout_out,
    output logic [DW-1:0]       rdata_out,
    output logic [NSIDE*DW-1:0] side_out,
    output logic                stall_out,
    output logic                pr_err
);

    localparam int CW = (PR_TMO > 0) ? $clog2(PR_TMO + 1) : 1;
    localparam int SW = NSIDE * DW;
    localparam int HW = 3 * DW + SW;
    localparam int OW = 1 + 4 * DW + SW;

    localparam logic [DW-1:0] BASE  = DW'(PR_BASE);
    localparam logic [DW-1:0] FILL  = DW'(TMO_FILL);
    localparam logic [CW-1:0] TMO_C = CW'(PR_TMO);

    wb_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall_q, stall_d;
    logic          err_q, err_d;

    logic          pr_req;
    logic          clr;
    logic          hold_ld;
    logic [HW-1:0] hold_d, hold_q;
    logic [OW-1:0] out_d, out_q;

    assign pr_req = valid_in & mem_rd_in & (aluout_in >= BASE);
    assign clr    = reset | flush;
    assign hold_d = {pc_in, instr_in, aluout_in, side_in};

    // Output layout: {valid, pc, instr, aluout, rdata, side}
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        err_d   = 1'b0;
        hold_ld = 1'b0;
        out_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pr_req && !pr_rdy) begin
                    hold_ld = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    stall_d = 1'b1;
                end else if (valid_in) begin
                    out_d = {1'b1, hold_d[HW-1:SW],
                             pr_req ? pr_rd : dmout_in,
                             hold_d[SW-1:0]};
                end
            end
            ST_WAIT: begin
                if (pr_rdy) begin
                    out_d   = {1'b1, hold_q[HW-1:SW], pr_rd,
                               hold_q[SW-1:0]};
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO_C) begin
                    out_d   = {1'b1, hold_q[HW-1:SW], FILL,
                               hold_q[SW-1:0]};
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall_d = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            stall_d = 1'b0;
            err_d   = 1'b0;
            hold_ld = 1'b0;
            out_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    pipe_buf #(.W(HW)) u_hold (
        .clk (clk),
        .clr (clr),
        .ld  (hold_ld),
        .d   (hold_d),
        .q   (hold_q)
    );

    pipe_buf #(.W(OW)) u_out (
        .clk (clk),
        .clr (reset),
        .ld  (1'b1),
        .d   (out_d),
        .q   (out_q)
    );

    assign side_out   = out_q[SW-1:0];
    assign rdata_out  = out_q[SW+:DW];
    assign aluout_out = out_q[SW+DW+:DW];
    assign instr_out  = out_q[SW+2*DW+:DW];
    assign pc_out     = out_q[SW+3*DW+:DW];
    assign valid_out  = out_q[OW-1];
    assign stall_out  = stall_q;
    assign pr_err     = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage: memory loads,
// peripheral hits, waits, timeout, flush and reset aborts.
module tb_mem_wb_stage;

    localparam int DW    = 32;
    localparam int NSIDE = 4;
    localparam int TMO   = 15;

    typedef struct packed {
        logic          v;
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [31:0]   alu;
        logic [31:0]   rd;
        logic [127:0]  side;
        logic          stall;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    int nvec = 0;
    int nbad = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    mem_wb_stage_if #(.DW(DW), .NSIDE(NSIDE)) bus ();

    mem_wb_stage #(
        .DW     (DW),
        .NSIDE  (NSIDE),
        .PR_TMO (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.flush),
        .valid_in   (bus.valid_in),
        .mem_rd_in  (bus.mem_rd_in),
        .pc_in      (bus.pc_in),
        .instr_in   (bus.instr_in),
        .aluout_in  (bus.aluout_in),
        .dmout_in   (bus.dmout_in),
        .side_in    (bus.side_in),
        .pr_rd      (bus.pr_rd),
        .pr_rdy     (bus.pr_rdy),
        .valid_out  (bus.valid_out),
        .pc_out     (bus.pc_out),
        .instr_out  (bus.instr_out),
        .aluout_out (bus.aluout_out),
        .rdata_out  (bus.rdata_out),
        .side_out   (bus.side_out),
        .stall_out  (bus.stall_out),
        .pr_err     (bus.pr_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic rd,
                         input logic [31:0] pc,
                         input logic [31:0] alu,
                         input logic [31:0] dm,
                         input logic rdy,
                         input logic [31:0] prd);
        bus.valid_in  = v;
        bus.mem_rd_in = rd;
        bus.pc_in     = pc;
        bus.instr_in  = {pc[15:0], 16'h0013};
        bus.aluout_in = alu;
        bus.dmout_in  = dm;
        bus.side_in   = {pc, alu, dm, ~pc};
        bus.pr_rdy    = rdy;
        bus.pr_rd     = prd;
    endtask

    function automatic exp_t commit(input logic [31:0] pc,
                                    input logic [31:0] alu,
                                    input logic [31:0] dm,
                                    input logic [31:0] rd,
                                    input logic err);
        exp_t e;
        e.v     = 1'b1;
        e.pc    = pc;
        e.instr = {pc[15:0], 16'h0013};
        e.alu   = alu;
        e.rd    = rd;
        e.side  = {pc, alu, dm, ~pc};
        e.stall = 1'b0;
        e.err   = err;
        return e;
    endfunction

    function automatic exp_t bubble(input logic stall);
        exp_t e;
        e       = '0;
        e.stall = stall;
        return e;
    endfunction

    task automatic cyc(input string tag, input exp_t e);
        exp_t  obs;
        exp_t  want;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        obs  = {bus.valid_out, bus.pc_out, bus.instr_out,
                bus.aluout_out, bus.rdata_out, bus.side_out,
                bus.stall_out, bus.pr_err};
        nvec++;
        assert (obs === want) else begin
            nbad++;
            $error("FAIL %s got=%h exp=%h", t, obs, want);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.flush = 1'b0;
        drive(1, 1, 32'h100, 32'h7F04, 32'h1, 1, 32'h2);
        cyc("reset", bubble(0));
        reset = 1'b0;

        drive(1, 1, 32'h104, 32'h1000, 32'h1234, 0, 32'h9);
        cyc("mem_load", commit(32'h104, 32'h1000, 32'h1234, 32'h1234, 0));

        drive(1, 1, 32'h108, 32'h7F04, 32'h1111, 1, 32'hABCD);
        cyc("pr_hit", commit(32'h108, 32'h7F04, 32'h1111, 32'hABCD, 0));

        drive(1, 0, 32'h10C, 32'h7F04, 32'h2222, 0, 32'h0);
        cyc("pr_store", commit(32'h10C, 32'h7F04, 32'h2222, 32'h2222, 0));

        drive(1, 1, 32'h110, 32'h7EFF, 32'h3333, 0, 32'h4);
        cyc("below_base", commit(32'h110, 32'h7EFF, 32'h3333, 32'h3333, 0));

        drive(1, 1, 32'h114, 32'h7F00, 32'h4444, 1, 32'h77);
        cyc("at_base", commit(32'h114, 32'h7F00, 32'h4444, 32'h77, 0));

        drive(0, 1, 32'h118, 32'h7F04, 32'h5555, 0, 32'h0);
        cyc("invalid", bubble(0));

        drive(1, 1, 32'h400, 32'h7F04, 32'h6666, 0, 32'h0);
        cyc("wait_enter", bubble(1));
        drive(1, 0, 32'hBAD0, 32'h1, 32'hBAD1, 0, 32'h0);
        cyc("wait_1", bubble(1));
        cyc("wait_2", bubble(1));
        drive(1, 0, 32'hBAD2, 32'h2, 32'hBAD3, 1, 32'h55);
        cyc("wait_commit", commit(32'h400, 32'h7F04, 32'h6666, 32'h55, 0));

        drive(1, 1, 32'h500, 32'h7F08, 32'h7777, 0, 32'h0);
        cyc("tmo_enter", bubble(1));
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        for (int i = 0; i < TMO; i++) cyc("tmo_wait", bubble(1));
        cyc("tmo_commit",
            commit(32'h500, 32'h7F08, 32'h7777, 32'hDEADBEEF, 1));
        cyc("tmo_err_drop", bubble(0));

        drive(1, 1, 32'h600, 32'h7F0C, 32'h8888, 0, 32'h0);
        cyc("race_enter", bubble(1));
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        for (int i = 0; i < TMO; i++) cyc("race_wait", bubble(1));
        bus.pr_rdy = 1'b1;
        bus.pr_rd  = 32'h99;
        cyc("race_commit", commit(32'h600, 32'h7F0C, 32'h8888, 32'h99, 0));

        drive(1, 1, 32'h700, 32'h7F10, 32'h9999, 0, 32'h0);
        cyc("flush_enter", bubble(1));
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        cyc("flush_wait", bubble(1));
        bus.flush  = 1'b1;
        bus.pr_rdy = 1'b1;
        bus.pr_rd  = 32'h42;
        cyc("flush_abort", bubble(0));
        bus.flush = 1'b0;
        cyc("flush_no_commit", bubble(0));

        drive(1, 1, 32'h710, 32'h2000, 32'hAAAA, 0, 32'h0);
        cyc("post_flush", commit(32'h710, 32'h2000, 32'hAAAA, 32'hAAAA, 0));
        bus.flush = 1'b1;
        cyc("flush_idle", bubble(0));
        bus.flush = 1'b0;

        drive(1, 1, 32'h800, 32'h7F14, 32'hBBBB, 0, 32'h0);
        cyc("rst_enter", bubble(1));
        reset = 1'b1;
        cyc("rst_abort", bubble(0));
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 32'h0, 1, 32'h43);
        cyc("rst_no_commit", bubble(0));

        drive(1, 1, 32'h900, 32'h3000, 32'hCCCC, 0, 32'h0);
        cyc("pre_both", commit(32'h900, 32'h3000, 32'hCCCC, 32'hCCCC, 0));
        reset     = 1'b1;
        bus.flush = 1'b1;
        cyc("rst_and_flush", bubble(0));
        reset     = 1'b0;
        bus.flush = 1'b0;
        drive(1, 1, 32'h904, 32'h3004, 32'hDDDD, 0, 32'h0);
        cyc("after_both", commit(32'h904, 32'h3004, 32'hDDDD, 32'hDDDD, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
